// File: rtl/addr_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding
// and the program counter reset value.
package addr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FETCH2,
        ST_MEMACC,
        ST_ADVANCE
    } seq_state_e;

    localparam logic [15:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/addr_sequencer.sv
// Instruction/address sequencer FSM. Fetches opcodes (and the second byte
// of relative jumps), runs one memory access when needed, and advances pc.
// Ports: clk/rst_n; run gates new fetches; bus_* is a req/ack byte bus;
// pc/ir/longoffs and calc_* drive the external address calculator, whose
// calc_addr/calc_pcout come back in; dec_* come from the opcode decoder
// on ir; ld_data/ld_valid deliver load data; retire pulses per instruction.
module addr_sequencer
    import addr_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic        bus_wdata_en,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] pc,
    output logic [7:0]  ir,
    output logic [7:0]  longoffs,
    output logic        calc_mem,
    output logic        calc_stack,
    output logic        calc_jump,
    output logic        calc_longjump,
    input  logic [15:0] calc_addr,
    input  logic [15:0] calc_pcout,
    input  logic        dec_mem,
    input  logic        dec_stack,
    input  logic        dec_store,
    input  logic        dec_jump,
    input  logic        dec_long,
    input  logic        dec_taken,
    output logic [7:0]  ld_data,
    output logic        ld_valid,
    output logic        retire
);

    seq_state_e  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  ldd_q, ldd_d;
    logic        ldv_q, ldv_d;
    logic        pend_q, pend_d;
    logic        req_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            lo_q    <= 8'h00;
            ldd_q   <= 8'h00;
            ldv_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            lo_q    <= lo_d;
            ldd_q   <= ldd_d;
            ldv_q   <= ldv_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        lo_d          = lo_q;
        ldd_d         = ldd_q;
        ldv_d         = 1'b0;
        pend_d        = pend_q;
        req_c         = 1'b0;
        bus_we        = 1'b0;
        bus_wdata_en  = 1'b0;
        bus_addr      = pc_q;
        calc_mem      = 1'b0;
        calc_stack    = 1'b0;
        calc_jump     = 1'b0;
        calc_longjump = 1'b0;
        retire        = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                // pend_q keeps an issued request alive after run drops
                req_c = run | pend_q;
                if (req_c) begin
                    if (bus_ack) begin
                        ir_d    = bus_rdata;
                        pend_d  = 1'b0;
                        state_d = ST_DECODE;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                if (dec_jump)
                    state_d = ST_FETCH2;
                else if (dec_mem)
                    state_d = ST_MEMACC;
                else
                    state_d = ST_ADVANCE;
            end
            ST_FETCH2: begin
                // controls idle: calculator yields pc+1
                req_c    = 1'b1;
                bus_addr = calc_pcout;
                if (bus_ack) begin
                    lo_d    = bus_rdata;
                    pc_d    = calc_pcout;
                    state_d = ST_ADVANCE;
                end
            end
            ST_MEMACC: begin
                req_c        = 1'b1;
                calc_mem     = 1'b1;
                calc_stack   = dec_stack;
                bus_addr     = calc_addr;
                bus_we       = dec_store;
                bus_wdata_en = dec_store;
                if (bus_ack) begin
                    if (!dec_store) begin
                        ldd_d = bus_rdata;
                        ldv_d = 1'b1;
                    end
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                calc_jump     = dec_jump & dec_taken;
                calc_longjump = dec_long & dec_taken;
                pc_d          = calc_pcout;
                retire        = 1'b1;
                state_d       = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // reset withdraws the request without waiting for a clock edge
    assign bus_req  = req_c & rst_n;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign longoffs = lo_q;
    assign ld_data  = ldd_q;
    assign ld_valid = ldv_q;

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: run  in  1  permits starting a new instruction fetch.
REQ-004 SHALL have: bus_req  out  1; bus_we  out  1; bus_addr  out  16; bus_wdata_en  out  1 (store phase); bus_ack  in  1; bus_rdata  in  8.
REQ-005 SHALL have: pc  out  16, drives calculator pcin; ir  out  8, latched opcode; longoffs  out  8, latched second byte.
REQ-006 SHALL have calculator controls out, 1 bit each: calc_mem, calc_stack, calc_jump, calc_longjump.
REQ-007 SHALL have calculator results in: calc_addr  16; calc_pcout  16.
REQ-008 SHALL have decoder inputs, combinational on ir, 1 bit each: dec_mem, dec_stack, dec_store, dec_jump (two-byte relative), dec_long (register jump), dec_taken.
REQ-009 SHALL have: ld_data  out  8; ld_valid  out  1 (one-cycle pulse); retire  out  1 (one-cycle pulse).

Function
REQ-010 SHALL implement states FETCH, DECODE, FETCH2, MEMACC, ADVANCE.
REQ-011 FETCH: bus_req=run, bus_addr=pc, bus_we=0; on bus_req&bus_ack, ir<=bus_rdata, go DECODE.
REQ-012 DECODE (exactly 1 cycle, bus_req=0): dec_jump -> FETCH2; else dec_mem -> MEMACC; else -> ADVANCE.
REQ-013 FETCH2: calc controls all 0, bus_req=1, bus_addr=calc_pcout (pc+1); on ack longoffs<=bus_rdata, pc<=calc_pcout, go ADVANCE.
REQ-014 MEMACC: calc_mem=1, calc_stack=dec_stack, bus_addr=calc_addr, bus_we=dec_store, bus_wdata_en=dec_store; on ack: load -> ld_data<=bus_rdata and ld_valid pulses next cycle; go ADVANCE.
REQ-015 ADVANCE (1 cycle): calc_jump=dec_jump&dec_taken, calc_longjump=dec_long&dec_taken, calc_mem=0; pc<=calc_pcout; retire pulses; go FETCH.
REQ-016 Not-taken two-byte jump SHALL leave pc = opcode address+2; taken relative jump is relative to second-byte address.
REQ-017 Once asserted, bus_req, bus_addr, bus_we SHALL stay stable until the ack cycle; run falling SHALL NOT withdraw a pending FETCH request.
REQ-018 run=0 in FETCH with no request outstanding: hold state, pc unchanged, bus_req=0.
REQ-019 pc arithmetic wraps modulo 2^16 (0xFFFF+1 = 0x0000), inherited from calculator.
REQ-020 Outside states listed, calc controls SHALL be 0; bus_req=0 in DECODE and ADVANCE.
REQ-021 bus_ack while bus_req=0 SHALL be ignored.

Reset
REQ-022 rst_n low SHALL immediately force state=FETCH, pc=0x0000, ir=0x00, longoffs=0x00, ld_data=0x00, all other outputs 0.
REQ-023 Reset asserted mid-transfer SHALL drop bus_req asynchronously; no ld_valid or retire for the aborted instruction.
REQ-024 First fetch after reset release SHALL target 0x0000.

Structure
REQ-025 State encoding and reset PC constant SHALL live in the shared CPU package.
REQ-026 SHALL be one FSM module; the address calculator is instantiated by the parent, not inside this block.

Verification
REQ-027 Reset, run=1, ALU op at 0x0000 acked in 1 cycle -> retire on 3rd cycle after first request, pc=0x0001.
REQ-028 Jump at 0x0010, offs=0xF, longoffs=0xFE, taken -> second-byte fetch at 0x0011, final pc=0x0011+0xFFFE=0x000F.
REQ-029 Same jump not taken -> pc=0x0012, calc_jump=0 in ADVANCE.
REQ-030 Stack load, sp=0x20, offs=0x2, ack delayed 3 cycles -> bus_addr=0xFF22 held stable all 4 cycles, ld_valid once with rdata.
REQ-031 pc=0xFFFF ALU op -> pc=0x0000; run=0 after retire -> no bus_req, pc frozen.
REQ-032 rst_n low during MEMACC wait -> bus_req 0 same cycle, no retire, refetch at 0x0000.
